// File: rtl/alu_sequencer.sv
// ALU sequencer: accepts register/ALU commands, drives an external
// combinational ALU for one cycle and returns A plus {S,Z,P,CY}.
module alu_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_kind,
  input  logic [3:0] cmd_op,
  input  logic [2:0] cmd_reg,
  input  logic [7:0] cmd_imm,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_opcode,
  input  logic [7:0] alu_y,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [3:0] rsp_flags,
  output logic       rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_e;

  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_TX  = 4'h6;

  state_e     state_q, state_d;
  // Entries 0-6 are B..T; entry 7 is the accumulator A.
  logic [7:0] rf_q [8];
  logic [7:0] rf_d [8];
  logic [3:0] flags_q, flags_d;
  logic       err_q, err_d;
  logic [3:0] op_q, op_d;
  logic [7:0] opnd_q, opnd_d;

  logic       accept;
  logic [8:0] sum9;
  logic       cy;

  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rf_q    <= '{default: '0};
      flags_q <= '0;
      err_q   <= 1'b0;
      op_q    <= OP_TX;
      opnd_q  <= '0;
    end else begin
      state_q <= state_d;
      rf_q    <= rf_d;
      flags_q <= flags_d;
      err_q   <= err_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!cmd_kind[1] && !cmd_op[3]) state_d = S_ISSUE;
          else                            state_d = S_RESP;
        end
      end
      S_ISSUE: state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sum9 = {1'b0, rf_q[7]} + {1'b0, opnd_q};
    unique case (op_q)
      OP_ADD:  cy = sum9[8];
      OP_SUB:  cy = (rf_q[7] < opnd_q);
      default: cy = 1'b0;
    endcase
  end

  // Operand/opcode return to TX/0 whenever the next state is not ISSUE.
  always_comb begin
    rf_d    = rf_q;
    flags_d = flags_q;
    err_d   = err_q;
    op_d    = OP_TX;
    opnd_d  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (cmd_kind)
            2'b00, 2'b01: begin
              if (cmd_op[3]) begin
                err_d = 1'b1;
              end else begin
                op_d   = cmd_op;
                opnd_d = cmd_kind[0] ? cmd_imm : rf_q[cmd_reg];
              end
            end
            2'b10: rf_d[cmd_reg] = cmd_imm;
            2'b11: rf_d[cmd_reg] = rf_q[7];
          endcase
        end
      end
      S_ISSUE: begin
        rf_d[7] = alu_y;
        flags_d = {alu_y[7], (alu_y == 8'h00), ~^alu_y, cy};
      end
      S_RESP: begin
        if (rsp_ready) err_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    cmd_ready  = rst_n && (state_q == S_IDLE);
    rsp_valid  = (state_q == S_RESP);
    rsp_data   = rf_q[7];
    rsp_flags  = flags_q;
    rsp_err    = err_q;
    alu_a      = rf_q[7];
    alu_b      = opnd_q;
    alu_opcode = op_q;
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU attached.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_kind;
  logic [3:0] cmd_op;
  logic [2:0] cmd_reg;
  logic [7:0] cmd_imm;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_opcode;
  logic [7:0] alu_y;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [3:0] rsp_flags;
  logic       rsp_err;

  int n_chk  = 0;
  int n_fail = 0;
  int n_rsp  = 0;
  int n_push = 0;
  bit started = 1'b0;
  logic [12:0] exp_q [$];

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_kind   (cmd_kind),
    .cmd_op     (cmd_op),
    .cmd_reg    (cmd_reg),
    .cmd_imm    (cmd_imm),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_y      (alu_y),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_flags  (rsp_flags),
    .rsp_err    (rsp_err)
  );

  always_comb begin
    alu_y = 8'h00;
    case (alu_opcode)
      4'h0: alu_y = alu_a | alu_b;
      4'h1: alu_y = alu_a & alu_b;
      4'h2: alu_y = ~alu_a;
      4'h3: alu_y = alu_a ^ alu_b;
      4'h4: alu_y = alu_a + alu_b;
      4'h5: alu_y = alu_a - alu_b;
      4'h6: alu_y = alu_b;
      4'h7: alu_y = alu_a >> alu_b[2:0];
      default: alu_y = 8'h00;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      logic [12:0] e;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp: got data 0x%0h want no response",
                 rsp_data);
      end else begin
        e = exp_q.pop_front();
        n_rsp++;
        chk("rsp_data", 32'(rsp_data), 32'(e[12:5]));
        chk("rsp_flags", 32'(rsp_flags), 32'(e[4:1]));
        chk("rsp_err", 32'(rsp_err), 32'(e[0]));
      end
    end
  end

  always @(negedge clk) begin
    if (started) chk("opcode_legal", 32'(alu_opcode <= 4'h7), 32'd1);
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(cmd_ready), 32'd1);
  endtask

  task automatic wait_rsp(input int el);
    int lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(el));
  endtask

  task automatic drive(input logic [1:0] k, input logic [3:0] op,
                       input logic [2:0] r, input logic [7:0] imm);
    cmd_kind  = k;
    cmd_op    = op;
    cmd_reg   = r;
    cmd_imm   = imm;
    cmd_valid = 1'b1;
  endtask

  task automatic send(input logic [1:0] k, input logic [3:0] op,
                      input logic [2:0] r, input logic [7:0] imm,
                      input logic [7:0] ed, input logic [3:0] ef,
                      input logic ee, input int el);
    wait_idle();
    if (cmd_ready) begin
      exp_q.push_back({ed, ef, ee});
      n_push++;
      drive(k, op, r, imm);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      wait_rsp(el);
    end
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    cmd_kind  = 2'b00;
    cmd_op    = 4'h0;
    cmd_reg   = 3'd0;
    cmd_imm   = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'h00);
    chk("rst_alu_op", 32'(alu_opcode), 32'h6);
    chk("rst_alu_b", 32'(alu_b), 32'h00);
    chk("rst_flags", 32'(rsp_flags), 32'h0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    started = 1'b1;

    send(2'b10, 4'h0, 3'd7, 8'h3C, 8'h3C, 4'b0000, 1'b0, 1);
    send(2'b10, 4'h0, 3'd0, 8'h0F, 8'h3C, 4'b0000, 1'b0, 1);
    send(2'b00, 4'h4, 3'd0, 8'h00, 8'h4B, 4'b0010, 1'b0, 2);
    send(2'b10, 4'h0, 3'd7, 8'h05, 8'h05, 4'b0010, 1'b0, 1);
    send(2'b01, 4'h5, 3'd0, 8'h07, 8'hFE, 4'b1001, 1'b0, 2);
    send(2'b10, 4'h0, 3'd7, 8'hA5, 8'hA5, 4'b1001, 1'b0, 1);
    send(2'b00, 4'h3, 3'd7, 8'h00, 8'h00, 4'b0110, 1'b0, 2);
    send(2'b10, 4'h0, 3'd7, 8'h80, 8'h80, 4'b0110, 1'b0, 1);
    send(2'b01, 4'h7, 3'd0, 8'h03, 8'h10, 4'b0000, 1'b0, 2);
    send(2'b00, 4'h9, 3'd0, 8'h00, 8'h10, 4'b0000, 1'b1, 1);
    send(2'b11, 4'h0, 3'd2, 8'h00, 8'h10, 4'b0000, 1'b0, 1);
    send(2'b10, 4'h0, 3'd7, 8'h03, 8'h03, 4'b0000, 1'b0, 1);
    send(2'b00, 4'h0, 3'd2, 8'h00, 8'h13, 4'b0000, 1'b0, 2);
    send(2'b01, 4'h2, 3'd0, 8'h00, 8'hEC, 4'b1000, 1'b0, 2);
    send(2'b01, 4'h4, 3'd0, 8'h20, 8'h0C, 4'b0011, 1'b0, 2);
    send(2'b01, 4'h6, 3'd0, 8'h81, 8'h81, 4'b1010, 1'b0, 2);
    send(2'b01, 4'h5, 3'd0, 8'h01, 8'h80, 4'b1000, 1'b0, 2);
    send(2'b01, 4'h5, 3'd0, 8'h80, 8'h00, 4'b0110, 1'b0, 2);

    // Back-pressure: response held while a second command waits.
    wait_idle();
    rsp_ready = 1'b0;
    send(2'b10, 4'h0, 3'd1, 8'h55, 8'h00, 4'b0110, 1'b0, 1);
    drive(2'b00, 4'h0, 3'd1, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", 32'(rsp_data), 32'h00);
      chk("hold_flags", 32'(rsp_flags), 32'b0110);
      chk("hold_ready", 32'(cmd_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_accept_delay", 32'(n), 32'd1);
    exp_q.push_back({8'h55, 4'b0010, 1'b0});
    n_push++;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_rsp(2);

    // Reset during ISSUE of an ADD aborts it.
    wait_idle();
    drive(2'b01, 4'h4, 3'd0, 8'h11);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_alu_a", 32'(alu_a), 32'h00);
    chk("abort_alu_op", 32'(alu_opcode), 32'h6);
    chk("abort_alu_b", 32'(alu_b), 32'h00);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("abort_ready_after", 32'(cmd_ready), 32'd1);
    repeat (5) @(posedge clk);
    send(2'b11, 4'h0, 3'd7, 8'h00, 8'h00, 4'b0000, 1'b0, 1);

    repeat (4) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("rsp_count", 32'(n_rsp), 32'(n_push));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
